// File: rtl/fpga_verdict.sv
// Watches one test-program run from reset release and latches a sticky PASS/FAIL/TIMEOUT verdict on LEDs.
// Optional VERDICT_BLINK_EN: free-running blink counter makes led_busy (RUN) and led_fail (TIMEOUT) blink.
module fpga_verdict #(
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned BLINK_DIV   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   finished,
    input  logic                   success,
    output logic                   done,
    output logic                   timed_out,
    output logic                   led_busy,
    output logic                   led_pass,
    output logic                   led_fail,
    output logic [COUNT_WIDTH-1:0] cycles
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam bit                     TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [COUNT_WIDTH-1:0] CYCLES_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] cycles_nxt;
    logic                   done_nxt;
    logic                   timed_out_nxt;
    logic                   led_busy_nxt;
    logic                   led_pass_nxt;
    logic                   led_fail_nxt;
    logic                   blink;

`ifdef VERDICT_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt;
    logic [BLINK_DIV-1:0] blink_cnt_nxt;

    assign blink_cnt_nxt = blink_cnt + BLINK_DIV'(1);
    // LEDs are registered alongside the counter, so they follow its post-edge MSB.
    assign blink = blink_cnt_nxt[BLINK_DIV-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
        end
    end
`else
    assign blink = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_RUN;
            cycles <= '0;
        end else begin
            state  <= state_nxt;
            cycles <= cycles_nxt;
        end
    end

    // A finish on the timeout edge takes priority, so the timeout rule sits under finished=0.
    always_comb begin
        state_nxt  = state;
        cycles_nxt = cycles;
        if (state == S_RUN) begin
            if (finished) begin
                state_nxt = success ? S_PASS : S_FAIL;
            end else begin
                if (cycles != CYCLES_MAX) begin
                    cycles_nxt = cycles + COUNT_WIDTH'(1);
                end
                if (TIMEOUT_EN && (cycles == TIMEOUT_LAST)) begin
                    state_nxt = S_TIMEOUT;
                end
            end
        end
    end

    always_comb begin
        done_nxt      = (state_nxt != S_RUN);
        timed_out_nxt = (state_nxt == S_TIMEOUT);
        led_busy_nxt  = (state_nxt == S_RUN) && blink;
        led_pass_nxt  = (state_nxt == S_PASS);
        led_fail_nxt  = (state_nxt == S_FAIL) || ((state_nxt == S_TIMEOUT) && blink);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            timed_out <= 1'b0;
            led_busy  <= 1'b0;
            led_pass  <= 1'b0;
            led_fail  <= 1'b0;
        end else begin
            done      <= done_nxt;
            timed_out <= timed_out_nxt;
            led_busy  <= led_busy_nxt;
            led_pass  <= led_pass_nxt;
            led_fail  <= led_fail_nxt;
        end
    end

endmodule
